// File: rtl/seg7_scan_display_pkg.sv
// ----------------------------------------------------------------------------
// seg7_scan_display_pkg
//   Shared constants for the 7-segment scan display and its input-side
//   companion, the switch sampler.
//   - SCAN_PERIOD_DEFAULT: slot length minus 1 in sys_clk cycles.
//     The value gives 1 ms at 50 MHz and is the common scan timebase.
//   - SEG_*: active-high glyphs, bit order {g,f,e,d,c,b,a}.
//   - CODE_BLANK: the BCD code that decodes to an all-off digit.
// ----------------------------------------------------------------------------
package seg7_scan_display_pkg;

  localparam logic [15:0] SCAN_PERIOD_DEFAULT = 16'd49999;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage

// File: rtl/seg7_scan_display_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_display_if
//   Interface between the measurement datapath and the scan display.
//   master (datapath side): drives bcd_in, dp_in, load and blank_lz.
//                           Observes seg_out, dig_sel and frame_done.
//   slave  (display side) : the mirror image of master.
//   bcd_in     : packed BCD, where digit k = bcd_in[4k+3:4k]
//   dp_in      : decimal point enable, one bit per digit
//   load       : 1-cycle strobe that captures bcd_in/dp_in
//   blank_lz   : when 1, leading zeros are blanked
//   seg_out    : {dp,g,f,e,d,c,b,a}
//   dig_sel    : one-hot digit enable
//   frame_done : 1-cycle pulse at the end of the last digit slot
// ----------------------------------------------------------------------------
interface seg7_scan_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport master (
    output bcd_in, dp_in, load, blank_lz,
    input  seg_out, dig_sel, frame_done
  );

  modport slave (
    input  bcd_in, dp_in, load, blank_lz,
    output seg_out, dig_sel, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
//   Combinational decoder from a BCD code plus a decimal point to active-high
//   segments.
//   code_i : 4-bit code. 0-9 map to digits, 10-14 map to '-', 15 maps to blank.
//   dp_i   : decimal point, passed through to seg_o[7].
//   seg_o  : {dp,g,f,e,d,c,b,a}, active-high.
// ----------------------------------------------------------------------------
module seg7_decode
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph;

  // NOTE: assigning a default before the case means every path drives glyph,
  // so no latch is inferred.
  always_comb begin
    glyph = SEG_OFF;
    case (code_i)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      4'd10, 4'd11, 4'd12, 4'd13, 4'd14: glyph = SEG_DASH;
      default: glyph = SEG_OFF;
    endcase
  end

  assign seg_o = {dp_i, glyph};

endmodule

// File: rtl/seg7_scan_display.sv
// ----------------------------------------------------------------------------
// seg7_scan_display
//   Time-multiplexed driver for a common-anode 7-segment display bank.
//   Each digit gets one scan slot of SCAN_PERIOD+1 cycles.
//   The first BLANK_CYC cycles of every slot keep all digits off, which
//   prevents ghosting.
//   A new value is staged in a shadow register and moves to the display
//   register only at the frame boundary, so a frame never mixes old and new
//   data.
//   sys_clk : system clock
//   sys_rst : synchronous reset, active-high
//   bus     : seg7_scan_display_if.slave
//             Carries bcd_in, dp_in, load and blank_lz in.
//             Carries seg_out, dig_sel and frame_done out.
// ----------------------------------------------------------------------------
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter logic [15:0] SCAN_PERIOD = SCAN_PERIOD_DEFAULT,
  parameter int          NUM_DIGITS  = 8,
  parameter logic [15:0] BLANK_CYC   = 16'd500,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  seg7_scan_display_if.slave   bus
);

  localparam int                    IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_INACTIVE = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_INACTIVE = {NUM_DIGITS{ACTIVE_LOW}};

  // Timebase and digit index.
  logic [15:0]             slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        dig_idx_q,  dig_idx_d;
  logic                    slot_wrap, frame_wrap;

  // Shadow (staging) and display registers.
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_bcd_q,   disp_bcd_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q,    disp_dp_d;

  // Output registers.
  logic [7:0]              seg_q,        seg_d;
  logic [NUM_DIGITS-1:0]   dig_sel_q,    dig_sel_d;
  logic                    frame_done_q, frame_done_d;

  // Decode path.
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lz_run;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic [7:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   dig_on;

  // --------------------------------------------------------------------------
  // Timebase
  // --------------------------------------------------------------------------
  always_comb begin
    slot_wrap  = (slot_cnt_q == SCAN_PERIOD);
    frame_wrap = slot_wrap && (dig_idx_q == LAST_IDX);

    slot_cnt_d = slot_wrap ? 16'd0 : slot_cnt_q + 16'd1;
    dig_idx_d  = dig_idx_q;
    if (slot_wrap) begin
      dig_idx_d = (dig_idx_q == LAST_IDX) ? '0 : dig_idx_q + 1'b1;
    end

    // frame_done is computed from the next state, so the registered pulse
    // lines up with the cycle in which the last slot wraps.
    frame_done_d = (slot_cnt_d == SCAN_PERIOD) && (dig_idx_d == LAST_IDX);
  end

  // --------------------------------------------------------------------------
  // Shadow and display registers
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_bcd_d = bus.load ? bus.bcd_in : shadow_bcd_q;
    shadow_dp_d  = bus.load ? bus.dp_in  : shadow_dp_q;
    // shadow_*_d already includes a load in this cycle. A load that coincides
    // with the frame boundary therefore goes straight to the display.
    disp_bcd_d   = frame_wrap ? shadow_bcd_d : disp_bcd_q;
    disp_dp_d    = frame_wrap ? shadow_dp_d  : disp_dp_q;
  end

  // --------------------------------------------------------------------------
  // Leading-zero blanking
  // The scan runs from the MSB down. The run ends at the first digit that is
  // nonzero or has its dp set. Digit 0 is never blanked.
  // --------------------------------------------------------------------------
  always_comb begin
    lz_blank = '0;
    lz_run   = bus.blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run && (disp_bcd_q[4*k +: 4] == 4'd0) && !disp_dp_q[k];
      lz_blank[k] = lz_run;
    end
  end

  // --------------------------------------------------------------------------
  // Current digit, decode, and output next-state
  // --------------------------------------------------------------------------
  always_comb begin
    cur_code = disp_bcd_q[{dig_idx_q, 2'b00} +: 4];
    cur_dp   = disp_dp_q[dig_idx_q];
    if (lz_blank[dig_idx_q]) begin
      cur_code = CODE_BLANK;
      cur_dp   = 1'b0;
    end
  end

  seg7_decode u_decode (
    .code_i (cur_code),
    .dp_i   (cur_dp),
    .seg_o  (seg_raw)
  );

  always_comb begin
    seg_d  = seg_raw ^ SEG_INACTIVE;
    dig_on = '0;
    if (slot_cnt_q >= BLANK_CYC) begin
      dig_on = NUM_DIGITS'(1) << dig_idx_q;
    end
    dig_sel_d = dig_on ^ DIG_INACTIVE;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses <= so that every register samples the values
  // from before the edge. The always_comb blocks use = because later
  // statements in them depend on earlier ones.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      slot_cnt_q   <= '0;
      dig_idx_q    <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_INACTIVE;
      dig_sel_q    <= DIG_INACTIVE;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      dig_idx_q    <= dig_idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_display
//   Directed bench for seg7_scan_display with SCAN_PERIOD=9, NUM_DIGITS=4,
//   BLANK_CYC=2 and ACTIVE_LOW=1. One frame lasts 40 cycles.
//   cyc counts the clock edges since reset was released. The DUT outputs seen
//   at cycle cyc reflect the scan position cyc-1.
// ----------------------------------------------------------------------------
module tb_seg7_scan_display;

  localparam int          ND    = 4;
  localparam int          SLOT  = 10;
  localparam int          FRAME = ND * SLOT;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  seg7_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_display #(
    .SCAN_PERIOD (16'd9),
    .NUM_DIGITS  (ND),
    .BLANK_CYC   (16'd2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge sys_clk) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected active-low segment byte, from a hand-written glyph table.
  function automatic logic [7:0] exp_seg(input logic [3:0] code, input logic dp);
    logic [6:0] g;
    case (code)
      4'd0: g = 7'h3F;  4'd1: g = 7'h06;  4'd2: g = 7'h5B;  4'd3: g = 7'h4F;
      4'd4: g = 7'h66;  4'd5: g = 7'h6D;  4'd6: g = 7'h7D;  4'd7: g = 7'h07;
      4'd8: g = 7'h7F;  4'd9: g = 7'h6F;  4'd15: g = 7'h00;
      default: g = 7'h40;
    endcase
    return ~{dp, g};
  endfunction

  // Checks that run every cycle: at most one digit enabled, and frame_done
  // pulsing exactly on cycles 39, 79, ... after reset release.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      check("onehot", 32'($countones(~bus.dig_sel) <= 1), 32'd1);
      check("frame_done", bus.frame_done, 32'((cyc % FRAME) == FRAME - 1));
    end
  end

  // Wait until the outputs show digit k, slot cycle s.
  task automatic wait_out(input int k, input int s);
    int target;
    target = k * SLOT + s;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge sys_clk);
      if (cyc >= 1 && ((cyc - 1) % FRAME) == target) return;
    end
    check("wait_out_timeout", 32'((cyc - 1) % FRAME), 32'(target));
  endtask

  task automatic wait_frame_done(input string tag);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge sys_clk);
      if (bus.frame_done === 1'b1) return;
    end
    check(tag, bus.frame_done, 32'd1);
  endtask

  task automatic check_digit(input string tag, input int k, input logic [3:0] code, input logic dp);
    logic [ND-1:0] sel_exp;
    sel_exp = ~(ND'(1) << k);
    wait_out(k, 5);
    check({tag, "_sel"}, bus.dig_sel, sel_exp);
    check({tag, "_seg"}, bus.seg_out, exp_seg(code, dp));
  endtask

  task automatic load_word(input logic [15:0] bcd, input logic [3:0] dp);
    @(negedge sys_clk);
    bus.bcd_in = bcd;
    bus.dp_in  = dp;
    bus.load   = 1'b1;
    @(negedge sys_clk);
    bus.load   = 1'b0;
  endtask

  initial begin
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    sys_rst      = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    mon_en = 1'b1;

    // 1. Reset state, blank window and frame timing.
    check("rst_seg", bus.seg_out, 32'hFF);
    check("rst_sel", bus.dig_sel, 32'hF);
    sys_rst = 1'b0;
    check_digit("t1_d0", 0, 4'd0, 1'b0);
    wait_out(1, 1);
    check("t1_blank_sel", bus.dig_sel, 32'hF);
    check("t1_blank_seg", bus.seg_out, exp_seg(4'd0, 1'b0));
    wait_out(1, 2);
    check("t1_first_on", bus.dig_sel, 32'hD);
    wait_frame_done("t1_fd1");
    check("t1_fd1_cyc", cyc, 32'd39);

    // 2. A basic value, shown after one frame boundary.
    load_word(16'h1234, 4'b0000);
    wait_frame_done("t2_fd");
    check("t2_fd_cyc", cyc, 32'd79);
    check_digit("t2_d0", 0, 4'd4, 1'b0);
    check_digit("t2_d1", 1, 4'd3, 1'b0);
    check_digit("t2_d2", 2, 4'd2, 1'b0);
    check_digit("t2_d3", 3, 4'd1, 1'b0);

    // 3. Leading-zero blanking.
    bus.blank_lz = 1'b1;
    load_word(16'h0050, 4'b0000);
    wait_frame_done("t3a_fd");
    check_digit("t3a_d0", 0, 4'd0, 1'b0);
    check_digit("t3a_d1", 1, 4'd5, 1'b0);
    check_digit("t3a_d2", 2, 4'd15, 1'b0);
    check_digit("t3a_d3", 3, 4'd15, 1'b0);
    load_word(16'h0000, 4'b0000);
    wait_frame_done("t3b_fd");
    check_digit("t3b_d0", 0, 4'd0, 1'b0);
    check_digit("t3b_d1", 1, 4'd15, 1'b0);
    check_digit("t3b_d2", 2, 4'd15, 1'b0);
    check_digit("t3b_d3", 3, 4'd15, 1'b0);

    // 4. A mid-frame load is held back; a load on the boundary bypasses the
    //    shadow register.
    bus.blank_lz = 1'b0;
    wait_out(1, 5);
    load_word(16'h1111, 4'b0000);
    check_digit("t4_old_d2", 2, 4'd0, 1'b0);
    check_digit("t4_old_d3", 3, 4'd0, 1'b0);
    wait_frame_done("t4_fd");
    bus.bcd_in = 16'h2222;
    bus.dp_in  = 4'b0000;
    bus.load   = 1'b1;
    @(negedge sys_clk);
    bus.load   = 1'b0;
    check_digit("t4_byp_d0", 0, 4'd2, 1'b0);
    check_digit("t4_byp_d1", 1, 4'd2, 1'b0);
    check_digit("t4_byp_d2", 2, 4'd2, 1'b0);
    check_digit("t4_byp_d3", 3, 4'd2, 1'b0);

    // 5. Dash, blank and decimal point.
    load_word(16'hFA09, 4'b0010);
    wait_frame_done("t5_fd");
    check_digit("t5_d0", 0, 4'd9, 1'b0);
    check_digit("t5_d1", 1, 4'd0, 1'b1);
    check_digit("t5_d2", 2, 4'd10, 1'b0);
    check_digit("t5_d3", 3, 4'd15, 1'b0);

    // 5b. A set dp ends the leading-zero run.
    bus.blank_lz = 1'b1;
    load_word(16'h0005, 4'b0100);
    wait_frame_done("t5b_fd");
    check_digit("t5b_d0", 0, 4'd5, 1'b0);
    check_digit("t5b_d1", 1, 4'd0, 1'b0);
    check_digit("t5b_d2", 2, 4'd0, 1'b1);
    check_digit("t5b_d3", 3, 4'd15, 1'b0);

    // 6. A reset mid-slot on digit 2 restarts the scan and clears the display.
    bus.blank_lz = 1'b0;
    wait_out(2, 4);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("t6_seg", bus.seg_out, 32'hFF);
    check("t6_sel", bus.dig_sel, 32'hF);
    check("t6_fd", bus.frame_done, 32'd0);
    sys_rst = 1'b0;
    check_digit("t6_d0", 0, 4'd0, 1'b0);
    check_digit("t6_d2", 2, 4'd0, 1'b0);
    wait_frame_done("t6_fd1");
    check("t6_fd1_cyc", cyc, 32'd39);

    @(negedge sys_clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
